wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of bus-phase cycles without ACK_I before the bridge aborts; legal range 1..65535.
REQ-002 CLK_I  in  1  single clock; all logic rising-edge.
REQ-003 RST_I  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  bridge accepts command this cycle.
REQ-006 cmd_we  in  1  1=write, 0=read.
REQ-007 cmd_adr  in  32  byte address.
REQ-008 cmd_dat  in  32  write data.
REQ-009 cmd_sel  in  4  byte lane selects.
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  consumer takes response.
REQ-012 rsp_dat  out  32  read data, 0 for writes and errors.
REQ-013 rsp_err  out  1  transaction timed out.
REQ-014 ADR_O, DAT_O  out  32 each  Wishbone address and write data.
REQ-015 DAT_I  in  32  Wishbone read data.
REQ-016 WE_O  out  1; SEL_O  out  4; STB_O  out  1; CYC_O  out  1  Wishbone classic master controls.
REQ-017 ACK_I  in  1  Wishbone slave acknowledge.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-020 On acceptance, the bridge SHALL register cmd_adr, cmd_dat, cmd_sel and cmd_we onto ADR_O, DAT_O, SEL_O and WE_O, and SHALL enter BUS, with CYC_O=STB_O=1 from the next cycle.
REQ-021 In BUS, ADR_O, DAT_O, SEL_O, WE_O, CYC_O and STB_O SHALL stay stable until the terminating edge.
REQ-022 ACK_I SHALL be sampled only while STB_O=1; ACK_I is ignored in IDLE and RESP.
REQ-023 On an edge in BUS with ACK_I=1, the bridge SHALL capture DAT_I into rsp_dat (reads) or 0 (writes), set rsp_err=0, drop CYC_O/STB_O, and enter RESP.
REQ-024 A 16-bit wait counter SHALL clear on entry to BUS and increment on each BUS edge without ACK_I.
REQ-025 When the counter equals TIMEOUT-1 and ACK_I=0, the bridge SHALL drop CYC_O/STB_O, set rsp_err=1 and rsp_dat=0, and enter RESP; the bus phase therefore lasts exactly TIMEOUT cycles.
REQ-026 If ACK_I=1 on the timeout edge, ACK SHALL win (rsp_err=0).
REQ-027 In RESP, rsp_valid=1 and rsp_dat/rsp_err SHALL be held stable until rsp_ready=1; on that edge the bridge SHALL return to IDLE.
REQ-028 cmd_ready SHALL not assert in the RESP cycle; minimum throughput is one transaction per 3 cycles (IDLE, BUS, RESP) with zero-wait ACK and rsp_ready=1.
REQ-029 The bridge SHALL never have more than one transaction outstanding, and no command SHALL be accepted while rsp_valid=1.

Reset
REQ-030 When RST_I=0, all outputs SHALL go to 0 immediately (cmd_ready=0, rsp_valid=0, CYC_O=STB_O=0, buses 0), the state SHALL be IDLE, and the counter SHALL be 0.
REQ-031 Reset asserted during BUS or RESP SHALL abort the transaction silently; no response is produced after release.
REQ-032 After RST_I deassertion, cmd_ready SHALL assert in the first cycle.

Structure
REQ-033 A shared package wb_pkg SHALL hold the FSM state enum, WB_AW=32, WB_DW=32, WB_SELW=4 and the timeout counter width.
REQ-034 The wait counter SHALL be a sub-module wb_timeout_cnt (ports: clear, enable, limit, expired).

Verification
REQ-035 Write 0x1000/0xDEADBEEF/sel 0xF, with ACK_I on the 1st BUS cycle -> ADR_O=0x1000 and WE_O=1 for one cycle, then rsp_valid=1, rsp_err=0 and rsp_dat=0 the next cycle.
REQ-036 Read 0x2004, with ACK_I after 3 wait cycles and DAT_I=0x12345678 -> CYC_O high 4 cycles, then rsp_dat=0x12345678.
REQ-037 TIMEOUT=8 and no ACK_I -> STB_O high exactly 8 cycles, then rsp_err=1 and rsp_dat=0.
REQ-038 TIMEOUT=8 with ACK_I on the 8th cycle -> rsp_err=0 and data captured.
REQ-039 rsp_ready held 0 for 5 cycles, with a second command pending -> response held stable and cmd_ready=0 throughout; the second command is accepted the cycle after the handshake.
REQ-040 RST_I pulsed low mid-BUS -> CYC_O/STB_O drop asynchronously; no rsp_valid after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command bridge.
//   WB_AW / WB_DW / WB_SELW : Wishbone address, data and byte-select widths
//   TMO_W                   : width of the bus-phase wait counter
//   state_t                 : bridge FSM states
package wb_pkg;

  localparam int WB_AW   = 32;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;
  localparam int TMO_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-phase wait counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restart counting from zero (entry into the bus phase)
//   enable     : count one waited cycle
//   limit      : value at which the phase is considered expired
//   expired    : counter currently equals limit
module wb_timeout_cnt
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/wb_cmd_master.sv
// Command/response to Wishbone classic single-transfer master bridge.
//   CLK_I, RST_I          : clock, asynchronous active-low reset
//   cmd_*                 : valid/ready command channel (we, adr, dat, sel)
//   rsp_*                 : valid/ready response channel (dat, err)
//   ADR_O, DAT_O, SEL_O,
//   WE_O, CYC_O, STB_O    : Wishbone master outputs
//   DAT_I, ACK_I          : Wishbone slave read data and acknowledge
// One transaction at a time: IDLE accepts, BUS drives the cycle until ACK_I
// or TIMEOUT cycles elapse, RESP holds the result until it is consumed.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  input  logic [WB_SELW-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic [WB_AW-1:0]   ADR_O,
  output logic [WB_DW-1:0]   DAT_O,
  input  logic [WB_DW-1:0]   DAT_I,
  output logic               WE_O,
  output logic [WB_SELW-1:0] SEL_O,
  output logic               STB_O,
  output logic               CYC_O,
  input  logic               ACK_I
);

  // Counter runs 0..TIMEOUT-1, so the bus phase lasts exactly TIMEOUT cycles.
  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

  state_t state, state_nxt;
  logic   accept;
  logic   ack_hit;
  logic   tmo_hit;
  logic   expired;

  // Gated by reset so cmd_ready is 0 while RST_I is low, 1 right after release.
  assign cmd_ready = (state == IDLE) & RST_I;
  assign accept    = cmd_valid & cmd_ready;

  // STB_O is high exactly in BUS, so ACK_I is only looked at there.
  assign ack_hit   = (state == BUS) & ACK_I;
  assign tmo_hit   = (state == BUS) & ~ACK_I & expired;

  assign CYC_O     = (state == BUS);
  assign STB_O     = (state == BUS);
  assign rsp_valid = (state == RESP);

  wb_timeout_cnt u_tmo (
    .clk     (CLK_I),
    .rst_n   (RST_I),
    .clear   (accept),
    .enable  ((state == BUS) & ~ACK_I),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUS;
      BUS:     if (ack_hit || tmo_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wishbone request registers: loaded on accept, held through BUS,
  // returned to zero once the cycle terminates.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ADR_O <= '0;
      DAT_O <= '0;
      SEL_O <= '0;
      WE_O  <= 1'b0;
    end else if (accept) begin
      ADR_O <= cmd_adr;
      DAT_O <= cmd_dat;
      SEL_O <= cmd_sel;
      WE_O  <= cmd_we;
    end else if (ack_hit || tmo_hit) begin
      ADR_O <= '0;
      DAT_O <= '0;
      SEL_O <= '0;
      WE_O  <= 1'b0;
    end
  end

  // Response registers: written only on the terminating edge, so they stay
  // stable for the whole RESP state. ACK wins over a simultaneous timeout.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else if (ack_hit) begin
      rsp_dat <= WE_O ? '0 : DAT_I;
      rsp_err <= 1'b0;
    end else if (tmo_hit) begin
      rsp_dat <= '0;
      rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master (TIMEOUT=8): directed scenarios followed by
// random transactions checked against a transaction-level model.
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I = '0;
  logic        WE_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        CYC_O;
  logic        ACK_I = 1'b0;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .ADR_O     (ADR_O),
    .DAT_O     (DAT_O),
    .DAT_I     (DAT_I),
    .WE_O      (WE_O),
    .SEL_O     (SEL_O),
    .STB_O     (STB_O),
    .CYC_O     (CYC_O),
    .ACK_I     (ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction, starting and ending on a falling edge with the
  // bridge idle. ack_delay = wait cycles before ACK_I (>= TO means none in
  // time); rsp_wait = cycles rsp_ready is held low. A junk command is kept
  // pending during RESP to prove it is not taken early.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_delay, input logic [31:0] rd,
                        input int rsp_wait);
    int          bus_cyc;
    int          exp_bus;
    logic        exp_err;
    logic [31:0] exp_dat;

    // Reference model of the transaction outcome.
    exp_err = (ack_delay >= TO);
    exp_bus = exp_err ? TO : ack_delay + 1;
    exp_dat = (exp_err || we) ? 32'h0 : rd;

    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge CLK_I);
    cmd_valid = 1'b0;

    bus_cyc = 0;
    while (STB_O === 1'b1 && bus_cyc < 100) begin
      bus_cyc++;
      chk("bus_adr", ADR_O, adr);
      chk("bus_dat", DAT_O, dat);
      chk("bus_sel", {28'b0, SEL_O}, {28'b0, sel});
      chk("bus_we", {31'b0, WE_O}, {31'b0, we});
      chk("bus_cyc", {31'b0, CYC_O}, 32'd1);
      chk("bus_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      ACK_I = (bus_cyc == ack_delay + 1);
      DAT_I = ACK_I ? rd : $urandom;
      if (we && ACK_I) DAT_I = $urandom | 32'h1;
      @(negedge CLK_I);
    end
    chk("bus_length", bus_cyc, exp_bus);

    cmd_valid = 1'b1;
    cmd_we    = $urandom;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = $urandom;
    for (int i = 0; i <= rsp_wait; i++) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_dat", rsp_dat, exp_dat);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      chk("rsp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rsp_stb", {31'b0, STB_O}, 32'd0);
      ACK_I     = $urandom;
      DAT_I     = $urandom;
      rsp_ready = (i == rsp_wait);
      @(negedge CLK_I);
    end
    rsp_ready = 1'b0;
    ACK_I     = 1'b0;
    cmd_valid = 1'b0;
    chk("rsp_done", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_cyc", {31'b0, CYC_O}, 32'd0);
    chk("rst_stb", {31'b0, STB_O}, 32'd0);
    chk("rst_adr", ADR_O, 32'd0);
    chk("rst_dat", DAT_O, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    #1;
    chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge CLK_I);

    // Zero-wait write, read with 3 waits, timeout, ACK on the timeout cycle,
    // response back-pressure with a pending command.
    do_txn(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
    do_txn(1'b0, 32'h2004, 32'h0, 4'hF, 3, 32'h12345678, 0);
    do_txn(1'b0, 32'h3000, 32'h0, 4'h3, 50, 32'hCAFEF00D, 0);
    do_txn(1'b0, 32'h3004, 32'h0, 4'hC, TO - 1, 32'hA5A55A5A, 1);
    do_txn(1'b1, 32'h4000, 32'h11223344, 4'h1, 1, 32'h0, 5);
    do_txn(1'b0, 32'h4004, 32'h0, 4'hF, 0, 32'h0BADCAFE, 0);

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      do_txn($urandom, $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)));
    end

    // Reset pulsed in the middle of a bus phase
    chk("pre_rst_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h5000;
    cmd_sel   = 4'hF;
    @(negedge CLK_I);
    cmd_valid = 1'b0;
    chk("mid_bus_stb", {31'b0, STB_O}, 32'd1);
    @(negedge CLK_I);
    #2;
    RST_I = 1'b0;
    #1;
    chk("async_stb", {31'b0, STB_O}, 32'd0);
    chk("async_cyc", {31'b0, CYC_O}, 32'd0);
    chk("async_adr", ADR_O, 32'd0);
    chk("async_ready", {31'b0, cmd_ready}, 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    ACK_I = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_no_stb", {31'b0, STB_O}, 32'd0);
    end
    ACK_I = 1'b0;
    do_txn(1'b0, 32'h6000, 32'h0, 4'hF, 2, 32'h87654321, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
